// File: rtl/fifo_stream_reader.sv
// Read-side partner of the synchronous FIFO. Drains it into a 2-entry skid
// buffer and presents words on a valid/ready stream at 1 word/cycle.
module fifo_stream_reader #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             fifo_empty,
    output logic             fifo_read_en,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e             occ_r;
    occ_e             occ_s;
    logic             inflight_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_s;
    logic [WIDTH-1:0] tail_r;
    logic [WIDTH-1:0] tail_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             pop_s;
    logic [2:0]       level_s;
    logic             read_en_s;

    // Read request: issue only if the word can land in the buffer after this cycle's pop.
    always_comb begin
        pop_s     = (occ_r != OCC_EMPTY) && m_ready;
        level_s   = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        read_en_s = !reset && !flush && !fifo_empty && (level_s < 3'd2);
    end

    // Buffer next-state: capture into the tail, pop from the head; flush overrides both.
    always_comb begin
        occ_s   = occ_r;
        head_s  = head_r;
        tail_s  = tail_r;
        count_s = count_r;
        if (flush) begin
            occ_s = OCC_EMPTY;
        end else begin
            if (pop_s) begin
                count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_s = count_r;
            end
            case (occ_r)
                OCC_EMPTY: begin
                    if (inflight_r) begin
                        head_s = fifo_data_out;
                        occ_s  = OCC_ONE;
                    end else begin
                        occ_s = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    // Capture with pop: the incoming word replaces the departing head.
                    if (inflight_r && pop_s) begin
                        head_s = fifo_data_out;
                    end else if (inflight_r) begin
                        tail_s = fifo_data_out;
                        occ_s  = OCC_TWO;
                    end else if (pop_s) begin
                        occ_s = OCC_EMPTY;
                    end else begin
                        occ_s = OCC_ONE;
                    end
                end
                OCC_TWO: begin
                    if (pop_s) begin
                        head_s = tail_r;
                        if (inflight_r) begin
                            tail_s = fifo_data_out;
                        end else begin
                            occ_s = OCC_ONE;
                        end
                    end else begin
                        occ_s = OCC_TWO;
                    end
                end
                default: begin
                    occ_s = OCC_EMPTY;
                end
            endcase
        end
    end

    // State registers; an asserted reset discards any word still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r      <= OCC_EMPTY;
            inflight_r <= 1'b0;
            head_r     <= {WIDTH{1'b0}};
            tail_r     <= {WIDTH{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            occ_r      <= occ_s;
            inflight_r <= read_en_s;
            head_r     <= head_s;
            tail_r     <= tail_s;
            count_r    <= count_s;
        end
    end

    assign fifo_read_en = read_en_s;
    assign m_valid      = (occ_r != OCC_EMPTY);
    assign m_data       = head_r;
    assign busy         = (occ_r != OCC_EMPTY) || inflight_r;
    assign word_count   = count_r;

endmodule
